// File: rtl/pwm_sequencer.sv
// pwm_sequencer
//   Sequenced controller for a single-channel PWM modulator. Generates the
//   carrier sawtooth from a programmable prescaler, walks the waveform ROM
//   (one sample per carrier period) and produces the registered PWM output.
//   Carrier prescale and table length arrive through a valid/ready port and
//   take effect only on carrier-period boundaries, so a period is never
//   reshaped mid-flight.
//
// Ports
//   clk           system clock (50 MHz)
//   rst           synchronous, active-high reset
//   enable        run request
//   cfg_valid     configuration offered
//   cfg_ready     configuration can be accepted
//   cfg_div       clk cycles per carrier tick (0 behaves as 1)
//   cfg_len       samples in table (0 behaves as 2^ADDR_W)
//   rom_addr      waveform ROM address (ROM has 1-cycle read latency)
//   rom_data      ROM output for the previous cycle's address
//   pwm_out       registered PWM output
//   period_start  one-cycle pulse on the first cycle of each carrier period
//   state_o       current state
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | counters held at 0, ROM address parked at 0, output low
// PRIME | one cycle: latch sample 0, advance the ROM address
// RUN   | carrier running, new sample latched on every period boundary
// DRAIN | carrier running until the current period ends, then IDLE

module pwm_sequencer #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int DIV_W   = 16,
    parameter int DEF_DIV = 977,
    parameter int DEF_LEN = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [ADDR_W-1:0] cfg_len,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              pwm_out,
    output logic              period_start,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] ONE_DIV = DIV_W'(1);

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   presc, div_q, sh_div, cfg_div_n;
    logic [DATA_W-1:0]  saw, duty_q;
    logic [ADDR_W-1:0]  addr_q, len_q, sh_len, len_use, last_addr, addr_nxt;
    logic               pend, running, tick, boundary, xfer;

    assign running   = (state == RUN) || (state == DRAIN);
    assign tick      = running && (presc == (div_q - ONE_DIV));
    assign boundary  = tick && (saw == '1);
    assign cfg_ready = ~pend;
    assign xfer      = cfg_valid && cfg_ready;
    assign cfg_div_n = (cfg_div == '0) ? ONE_DIV : cfg_div;

    // The boundary that applies a pending length already wraps against the
    // new length; ">=" lets a shrunken table wrap from any address past it.
    // A length of 0 wraps to all-ones here, i.e. the full 2^ADDR_W table.
    assign len_use   = pend ? sh_len : len_q;
    assign last_addr = len_use - 1'b1;
    assign addr_nxt  = (addr_q >= last_addr) ? '0 : addr_q + 1'b1;

    assign rom_addr  = addr_q;
    assign state_o   = state;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = PRIME;
            PRIME:   state_nxt = RUN;
            RUN:     if (!enable) state_nxt = DRAIN;
            DRAIN:   if (boundary) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc        <= '0;
            saw          <= '0;
            duty_q       <= '0;
            addr_q       <= '0;
            div_q        <= DIV_W'(DEF_DIV);
            len_q        <= ADDR_W'(DEF_LEN);
            sh_div       <= '0;
            sh_len       <= '0;
            pend         <= 1'b0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            period_start <= 1'b0;
            pwm_out      <= running && (duty_q > saw);

            if (running) begin
                if (tick) begin
                    presc <= '0;
                    saw   <= saw + 1'b1;
                end else begin
                    presc <= presc + ONE_DIV;
                end
            end else begin
                presc <= '0;
                saw   <= '0;
            end

            case (state)
                IDLE: addr_q <= '0;
                PRIME: begin
                    duty_q       <= rom_data;
                    addr_q       <= addr_nxt;
                    period_start <= 1'b1;
                end
                RUN: if (boundary) begin
                    duty_q       <= rom_data;
                    addr_q       <= addr_nxt;
                    period_start <= 1'b1;
                end
                DRAIN: if (boundary) addr_q <= '0;
                default: addr_q <= '0;
            endcase

            // While idle there is no period to protect, so configuration
            // lands directly. Otherwise it waits in the shadow; a transfer
            // on the boundary cycle itself can only happen with pend clear,
            // so it waits for the following boundary.
            if (state == IDLE) begin
                if (pend) begin
                    div_q <= sh_div;
                    len_q <= sh_len;
                    pend  <= 1'b0;
                end else if (xfer) begin
                    div_q <= cfg_div_n;
                    len_q <= cfg_len;
                end
            end else if (boundary && pend) begin
                div_q <= sh_div;
                len_q <= sh_len;
                pend  <= 1'b0;
            end else if (xfer) begin
                sh_div <= cfg_div_n;
                sh_len <= cfg_len;
                pend   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_sequencer.sv
// tb_pwm_sequencer
//   Directed bench for pwm_sequencer. The stimulus process pushes the
//   expected high count, length and end address of each carrier period into
//   a scoreboard queue; a monitor measures every period between period_start
//   pulses (or until the drain ends in IDLE) and checks against the queue.

module tb_pwm_sequencer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DIV_W  = 16;

    logic              clk;
    logic              rst;
    logic              enable;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DIV_W-1:0]  cfg_div;
    logic [ADDR_W-1:0] cfg_len;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              pwm_out;
    logic              period_start;
    logic [1:0]        state_o;

    pwm_sequencer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DIV_W  (DIV_W),
        .DEF_DIV(977),
        .DEF_LEN(200)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_div     (cfg_div),
        .cfg_len     (cfg_len),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pwm_out     (pwm_out),
        .period_start(period_start),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    logic [7:0] rom [256];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int hi;
        int len;
        int addr;
    } exp_t;

    exp_t sb_q[$];

    task automatic push(input int hi, input int len, input int addr);
        exp_t e;
        e.hi   = hi;
        e.len  = len;
        e.addr = addr;
        sb_q.push_back(e);
    endtask

    // Monitor: the window of a period runs from its period_start cycle up to
    // the next period_start (or the first IDLE cycle after a drain).
    int         hi_cnt = 0;
    int         len_cnt = 0;
    bit         active = 1'b0;
    logic [1:0] prev_state = 2'd0;

    always @(negedge clk) begin
        if (rst) begin
            active  = 1'b0;
            hi_cnt  = 0;
            len_cnt = 0;
        end else begin
            if (active && (period_start || (state_o == 2'd0 && prev_state == 2'd3))) begin
                check("sb_has_item", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("period_high", hi_cnt, e.hi);
                    check("period_len", len_cnt, e.len);
                    check("period_end_addr", int'(rom_addr), e.addr);
                end
            end
            if (period_start) begin
                active  = 1'b1;
                hi_cnt  = 0;
                len_cnt = 0;
            end else if (state_o == 2'd0) begin
                active = 1'b0;
            end
            if (active) begin
                hi_cnt  += int'(pwm_out);
                len_cnt += 1;
            end
        end
        prev_state = state_o;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for the next period_start; prev_ready is cfg_ready on the
    // cycle just before it (the boundary cycle).
    task automatic wait_ps(input string name, output logic prev_ready);
        logic pr;
        int   n;
        pr = cfg_ready;
        n  = 0;
        step();
        while (!period_start && n < 2000) begin
            pr = cfg_ready;
            step();
            n++;
        end
        if (!period_start) check({name, "_timeout"}, int'(period_start), 1);
        prev_ready = pr;
    endtask

    task automatic send_cfg(input int div, input int len);
        cfg_div   = DIV_W'(div);
        cfg_len   = ADDR_W'(len);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        logic pr;
        int   n;

        for (int i = 0; i < 256; i++) rom[i] = 8'((i * 37 + 5) % 256);
        rom[0] = 8'h00;
        rom[1] = 8'h40;
        rom[2] = 8'h80;
        rom[3] = 8'hFF;

        rst       = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        cfg_len   = '0;
        step();
        step();
        check("rst_div", int'(dut.div_q), 977);
        check("rst_len", int'(dut.len_q), 200);
        rst = 1'b0;

        for (int i = 0; i < 100; i++) begin
            step();
            check("idle_hold", int'({state_o, pwm_out, cfg_ready, period_start, rom_addr}),
                  int'({2'd0, 1'b0, 1'b1, 1'b0, 8'd0}));
        end

        // Four-sample table at one clk per tick
        send_cfg(1, 4);
        check("idle_cfg_ready", int'(cfg_ready), 1);
        check("idle_cfg_div", int'(dut.div_q), 1);
        check("idle_cfg_len", int'(dut.len_q), 4);

        push(0,   256, 2);
        push(64,  256, 3);
        push(128, 256, 0);
        push(255, 256, 1);
        push(0,   256, 2);
        push(128, 512, 3);
        push(128, 256, 0);

        enable = 1'b1;
        step();
        check("prime_state", int'(state_o), 1);
        step();
        check("run_state", int'(state_o), 2);
        check("first_ps", int'(period_start), 1);
        check("first_addr", int'(rom_addr), 1);

        for (int p = 1; p <= 4; p++) wait_ps("ps_run", pr);

        // Prescale change mid-period: held until the boundary
        for (int i = 0; i < 10; i++) step();
        send_cfg(2, 4);
        check("pend_ready_low", int'(cfg_ready), 0);
        wait_ps("ps_div2", pr);
        check("ready_low_at_boundary", int'(pr), 0);
        check("ready_back_after_boundary", int'(cfg_ready), 1);

        send_cfg(1, 4);
        check("pend_ready_low2", int'(cfg_ready), 0);
        wait_ps("ps_div1", pr);

        // Drain: enable drops at saw=100 of the 0x80 period
        for (int i = 0; i < 100; i++) step();
        enable = 1'b0;
        step();
        check("drain_state", int'(state_o), 3);
        n = 0;
        while (state_o != 2'd0 && n < 400) begin
            step();
            n++;
        end
        check("drain_to_idle", int'(state_o), 0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_after_drain", int'({state_o, pwm_out}), 0);
        end
        check("sb_drained_1", sb_q.size(), 0);

        // Full 256-entry table (len 0), zero prescale behaves as 1
        send_cfg(0, 0);
        check("div0_as_1", int'(dut.div_q), 1);
        check("len0_cfg", int'(dut.len_q), 0);

        for (int i = 0; i < 262; i++) push(int'(rom[i % 256]), 256, (i + 2) % 256);
        push(int'(rom[6]), 256, 0);
        push(int'(rom[7]), 256, 1);
        push(int'(rom[0]), 256, 2);
        push(int'(rom[1]), 256, 0);

        enable = 1'b1;
        step();
        step();
        check("run2_first_ps", int'(period_start), 1);
        for (int p = 1; p <= 262; p++) wait_ps("ps_full", pr);
        check("addr_before_shrink", int'(rom_addr), 7);

        send_cfg(1, 3);
        wait_ps("ps_shrink", pr);
        check("len_shrink_wrap", int'(rom_addr), 0);
        for (int p = 0; p < 3; p++) wait_ps("ps_len3", pr);

        // Reset mid-run with a pending configuration
        send_cfg(2, 5);
        check("pend_before_rst", int'(cfg_ready), 0);
        for (int i = 0; i < 50; i++) step();
        rst = 1'b1;
        step();
        check("rst_state", int'(state_o), 0);
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_saw", int'(dut.saw), 0);
        check("rst_div_back", int'(dut.div_q), 977);
        check("rst_len_back", int'(dut.len_q), 200);
        check("rst_pend_dropped", int'(dut.pend), 0);
        check("rst_ready", int'(cfg_ready), 1);
        check("rst_addr", int'(rom_addr), 0);
        rst    = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("sb_drained_2", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
